// File: rtl/seq_pattern_generator_pkg.sv
// seq_gen_pkg
// Shared definitions for the serial pattern generator:
//   - FSM state encoding (IDLE/SEND/GAP/DONE)
//   - default pattern width and the matching bit-index width
//   - small helper used to derive the busy flag from a state value
package seq_gen_pkg;

  localparam int PAT_W_DEFAULT = 8;
  localparam int IDX_W         = $clog2(PAT_W_DEFAULT);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEND = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  function automatic logic state_is_busy(input logic [1:0] st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/seq_pattern_generator_shifter.sv
// pattern_shifter
// Holds the captured pattern and length, plus the bit-index down-counter that
// walks the pattern MSB-first. At the end of a repetition the index reloads
// to the captured length so the next repetition can start without a bubble.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         capture pattern/len_m1 and set index to len_m1
//   advance      step the index (reloading to len_m1_cap after bit 0)
//   pattern      pattern bits to capture on load
//   len_m1       pattern length minus 1 to capture on load
//   next_bit     pattern bit at the index that will be held after this edge
//   next_first   that index is the first bit of a repetition
//   last_bit     the index currently held is bit 0 (end of repetition)
//
// next_bit/next_first look one edge ahead so the top level can register its
// serial outputs and still present the first bit in the cycle right after
// the start edge.
module pattern_shifter #(
  parameter int PAT_W = 8,
  parameter int IW    = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [PAT_W-1:0] pattern,
  input  logic [IW-1:0]    len_m1,
  output logic             next_bit,
  output logic             next_first,
  output logic             last_bit
);

  logic [PAT_W-1:0] pattern_cap_reg;
  logic [IW-1:0]    len_cap_reg;
  logic [IW-1:0]    idx_reg;

  logic [PAT_W-1:0] pattern_next;
  logic [IW-1:0]    len_next;
  logic [IW-1:0]    idx_next;

  always_comb begin
    pattern_next = pattern_cap_reg;
    len_next     = len_cap_reg;
    idx_next     = idx_reg;
    if (load) begin
      pattern_next = pattern;
      len_next     = len_m1;
      idx_next     = len_m1;
    end else if (advance) begin
      if (idx_reg == '0) begin
        idx_next = len_cap_reg;
      end else begin
        idx_next = idx_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_cap_reg <= '0;
      len_cap_reg     <= '0;
      idx_reg         <= '0;
    end else begin
      pattern_cap_reg <= pattern_next;
      len_cap_reg     <= len_next;
      idx_reg         <= idx_next;
    end
  end

  assign next_bit   = pattern_next[idx_next];
  assign next_first = (idx_next == len_next);
  assign last_bit   = (idx_reg == '0);

endmodule

// File: rtl/seq_pattern_generator.sv
// seq_pattern_generator
// Serial bit-pattern transmitter. On a start pulse in IDLE it captures the
// pattern, length, repeat count and gap, then shifts the pattern out
// MSB-first one bit per clock, repeat_m1+1 times, with gap idle cycles
// between repetitions, followed by a one-cycle done pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      single-cycle request, honoured only in IDLE
//   pattern    pattern bits, [len_m1:0] used
//   len_m1     pattern length minus 1
//   repeat_m1  repetitions minus 1
//   gap        idle cycles between repetitions (0 = back-to-back)
//   abort      cancel the current operation
//   busy       high whenever the FSM is not IDLE
//   bit_out    serial data (0 when bit_valid is low)
//   bit_valid  bit_out carries a pattern bit
//   first_bit  first bit of each repetition
//   done       one-cycle pulse after the final bit
//
// All outputs are flops loaded from the next-state logic, so they change
// only on clk (or clear at once on rst) and follow the FSM state exactly.
module seq_pattern_generator
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PAT_W-1:0]         pattern,
  input  logic [$clog2(PAT_W)-1:0] len_m1,
  input  logic [REP_W-1:0]         repeat_m1,
  input  logic [GAP_W-1:0]         gap,
  input  logic                     abort,
  output logic                     busy,
  output logic                     bit_out,
  output logic                     bit_valid,
  output logic                     first_bit,
  output logic                     done
);

  // Index width for this instance (the package value covers the default width).
  localparam int IW = $clog2(PAT_W);

  logic [1:0]       state_reg, state_next;
  logic [REP_W-1:0] rep_reg, rep_next;
  logic [GAP_W-1:0] gap_cap_reg, gap_cap_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;

  logic busy_reg, bit_out_reg, bit_valid_reg, first_bit_reg, done_reg;

  logic load, advance;
  logic next_bit, next_first, last_bit;

  pattern_shifter #(
    .PAT_W (PAT_W),
    .IW    (IW)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .advance    (advance),
    .pattern    (pattern),
    .len_m1     (len_m1),
    .next_bit   (next_bit),
    .next_first (next_first),
    .last_bit   (last_bit)
  );

  always_comb begin
    state_next   = state_reg;
    rep_next     = rep_reg;
    gap_cap_next = gap_cap_reg;
    gap_cnt_next = gap_cnt_reg;
    load         = 1'b0;
    advance      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          load         = 1'b1;
          rep_next     = repeat_m1;
          gap_cap_next = gap;
          state_next   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          // Advancing on bit 0 reloads the index, so a back-to-back
          // repetition continues with no bubble.
          advance = 1'b1;
          if (last_bit) begin
            if (rep_reg != '0) begin
              rep_next = rep_reg - 1'b1;
              if (gap_cap_reg != '0) begin
                gap_cnt_next = gap_cap_reg;
                state_next   = ST_GAP;
              end
            end else begin
              state_next = ST_DONE;
            end
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - 1'b1;
          // Leaving on a count of 1 gives exactly gap_cap idle cycles.
          if (gap_cnt_reg == GAP_W'(1)) begin
            state_next = ST_SEND;
          end
        end
      end

      default: begin
        // DONE lasts one cycle; start is ignored here.
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rep_reg       <= '0;
      gap_cap_reg   <= '0;
      gap_cnt_reg   <= '0;
      busy_reg      <= 1'b0;
      bit_out_reg   <= 1'b0;
      bit_valid_reg <= 1'b0;
      first_bit_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rep_reg       <= rep_next;
      gap_cap_reg   <= gap_cap_next;
      gap_cnt_reg   <= gap_cnt_next;
      busy_reg      <= state_is_busy(state_next);
      bit_valid_reg <= (state_next == ST_SEND);
      bit_out_reg   <= (state_next == ST_SEND) && next_bit;
      first_bit_reg <= (state_next == ST_SEND) && next_first;
      done_reg      <= (state_next == ST_DONE);
    end
  end

  assign busy      = busy_reg;
  assign bit_out   = bit_out_reg;
  assign bit_valid = bit_valid_reg;
  assign first_bit = first_bit_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_seq_pattern_generator.sv
module tb_seq_pattern_generator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [2:0] len_m1;
  logic [3:0] repeat_m1;
  logic [3:0] gap;
  logic       abort;
  logic       busy;
  logic       bit_out;
  logic       bit_valid;
  logic       first_bit;
  logic       done;

  int errors = 0;
  int checks = 0;

  seq_pattern_generator #(
    .PAT_W (8),
    .REP_W (4),
    .GAP_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len_m1    (len_m1),
    .repeat_m1 (repeat_m1),
    .gap       (gap),
    .abort     (abort),
    .busy      (busy),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .first_bit (first_bit),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is seen at the next posedge (edge 0) and the
  // task returns at the negedge of cycle 1.
  task automatic start_frame(input logic [7:0] p, input logic [2:0] l,
                             input logic [3:0] r, input logic [3:0] g);
    pattern   = p;
    len_m1    = l;
    repeat_m1 = r;
    gap       = g;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Checks n consecutive cycles; bit [n-1] of each vector is cycle 1.
  // At cycle poke (1-based), start is re-pulsed with a different pattern.
  task automatic expect_seq(input string tag, input int n,
                            input logic [31:0] ev, input logic [31:0] eo,
                            input logic [31:0] ef, input logic [31:0] ed,
                            input logic [31:0] eb, input int poke);
    for (int k = 0; k < n; k++) begin
      int b;
      b = n - 1 - k;
      check($sformatf("%s c%0d bit_valid", tag, k + 1), 32'(bit_valid), 32'(ev[b]));
      check($sformatf("%s c%0d bit_out",   tag, k + 1), 32'(bit_out),   32'(eo[b]));
      check($sformatf("%s c%0d first_bit", tag, k + 1), 32'(first_bit), 32'(ef[b]));
      check($sformatf("%s c%0d done",      tag, k + 1), 32'(done),      32'(ed[b]));
      check($sformatf("%s c%0d busy",      tag, k + 1), 32'(busy),      32'(eb[b]));
      if (k + 1 == poke) begin
        start     = 1'b1;
        pattern   = 8'hFF;
        len_m1    = 3'd7;
        repeat_m1 = 4'd5;
        gap       = 4'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    $display("%s: %0d cycles checked", tag, n);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    pattern   = '0;
    len_m1    = '0;
    repeat_m1 = '0;
    gap       = '0;
    abort     = 1'b0;

    #12;
    check("reset busy",      32'(busy),      32'd0);
    check("reset bit_valid", 32'(bit_valid), 32'd0);
    check("reset done",      32'(done),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: single frame 1011
    start_frame(8'h0B, 3'd3, 4'd0, 4'd0);
    expect_seq("t1 single", 6, 32'b111100, 32'b101100, 32'b100000,
               32'b000010, 32'b111110, 0);

    // Test 2: back-to-back repeats of 1101
    start_frame(8'h0D, 3'd3, 4'd2, 4'd0);
    expect_seq("t2 b2b", 14,
               32'b11111111111100, 32'b11011101110100,
               32'b10001000100000, 32'b00000000000010,
               32'b11111111111110, 0);

    // Test 3: gapped repeats of 10 with gap 2
    start_frame(8'h02, 3'd1, 4'd1, 4'd2);
    expect_seq("t3 gap", 8, 32'b11001100, 32'b10001000, 32'b10001000,
               32'b00000010, 32'b11111110, 0);

    // Test 4: abort during the 2nd bit
    start_frame(8'hA5, 3'd7, 4'd0, 4'd0);
    check("t4 c1 bit_out", 32'(bit_out), 32'd1);
    @(negedge clk);
    check("t4 c2 bit_out", 32'(bit_out), 32'd0);
    check("t4 c2 busy",    32'(busy),    32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4 post-abort %0d bit_valid", k), 32'(bit_valid), 32'd0);
      check($sformatf("t4 post-abort %0d busy", k),      32'(busy),      32'd0);
      check($sformatf("t4 post-abort %0d done", k),      32'(done),      32'd0);
      @(negedge clk);
    end
    $display("t4 abort: idle after abort checked");
    // abort together with start in IDLE: nothing starts
    abort = 1'b1;
    start_frame(8'hA5, 3'd7, 4'd0, 4'd0);
    abort = 1'b0;
    check("t4 abort+start busy", 32'(busy), 32'd0);
    @(negedge clk);
    start_frame(8'hA5, 3'd7, 4'd0, 4'd0);
    expect_seq("t4 restart", 10, 32'b1111111100, 32'b1010010100,
               32'b1000000000, 32'b0000000010, 32'b1111111110, 0);

    // Test 5: start re-pulsed with new fields mid-frame
    start_frame(8'h0B, 3'd3, 4'd0, 4'd0);
    expect_seq("t5 isolate", 8, 32'b11110000, 32'b10110000, 32'b10000000,
               32'b00001000, 32'b11111000, 2);

    // Test 6: async reset mid-GAP, then a 1-bit pattern
    start_frame(8'h02, 3'd1, 4'd1, 4'd2);
    expect_seq("t6 pre-reset", 3, 32'b110, 32'b100, 32'b100, 32'b000, 32'b111, 0);
    #2 rst = 1'b1;
    #1;
    check("t6 async busy",      32'(busy),      32'd0);
    check("t6 async bit_valid", 32'(bit_valid), 32'd0);
    check("t6 async bit_out",   32'(bit_out),   32'd0);
    check("t6 async first_bit", 32'(first_bit), 32'd0);
    check("t6 async done",      32'(done),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_frame(8'h01, 3'd0, 4'd0, 4'd0);
    expect_seq("t6 one-bit", 3, 32'b100, 32'b100, 32'b100, 32'b010, 32'b110, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_pattern_generator.md
Name: seq_pattern_generator

Overview:
Serial bit-pattern transmitter, the source side of the team's sequence detector.
- Captures a programmable pattern, length, repeat count and inter-frame gap on a start pulse.
- Shifts the pattern out MSB-first, one bit per clock, repeated N times with optional idle gaps.
- Drives the detector's serial input in the test fabric and the system-level pattern injector.

Parameters:
PAT_W, 8, maximum pattern length in bits (power of 2, >=2)
REP_W, 4, width of repeat-count field
GAP_W, 4, width of inter-repetition gap field

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request; sampled only in IDLE
pattern  in  PAT_W  pattern bits; bits [len_m1:0] are used
len_m1  in  $clog2(PAT_W)  pattern length minus 1
repeat_m1  in  REP_W  repetitions minus 1
gap  in  GAP_W  idle cycles between repetitions (0 = back-to-back)
abort  in  1  cancel current operation
busy  out  1  high whenever state != IDLE
bit_out  out  1  serial data; 0 when bit_valid low
bit_valid  out  1  bit_out carries a pattern bit this cycle
first_bit  out  1  marks the first bit of each repetition
done  out  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- Clocking: one clock, clk. rst is asynchronous, active-high.
- Reset (async assert):
  - State IDLE.
  - All counters and captured fields 0.
  - All outputs 0 immediately, without waiting for a clock edge.
- Outputs: all registered; no combinational path from inputs to outputs.
- FSM states IDLE, SEND, GAP, DONE:
  - IDLE: start=1 and abort=0 -> capture pattern, len_m1, repeat_m1, gap; bit index = len_m1; rep count = repeat_m1; go to SEND.
  - SEND: bit_valid=1, bit_out = pattern_cap[bit index], first_bit=1 when bit index == len_m1_cap.
    - Index > 0: decrement index.
    - Index == 0 and rep count > 0: decrement rep count, reload index; go to GAP if gap_cap != 0 (load gap counter with gap_cap), else stay in SEND (back-to-back, no bubble).
    - Index == 0 and rep count == 0: go to DONE.
  - GAP: bit_valid=0, bit_out=0. Decrement gap counter; leave for SEND when the counter reaches 1, giving exactly gap_cap idle cycles.
  - DONE: done=1, bit_valid=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- Latency: start sampled at edge 0 -> first valid bit in the cycle after edge 0.
- Busy cycles = (len_m1+1)*(repeat_m1+1) + gap*repeat_m1 + 1 (DONE).
- Input isolation: captured fields are frozen while busy. Changes to pattern, len_m1, repeat_m1 or gap mid-operation have no effect. start while busy is dropped, not queued.
- Abort:
  - In any non-IDLE state: next state is IDLE; bit_valid, first_bit and done are 0 from the next cycle; no done pulse.
  - abort=1 with start=1 in IDLE: abort wins and nothing starts.
- Arithmetic: all counters count down and are compared against captured values, so no wrap-around is possible. len_m1=0 yields a 1-bit pattern; len_m1=PAT_W-1 uses the full width.

Decomposition:
- Package seq_gen_pkg:
  - State encoding: IDLE=2'b00, SEND=2'b01, GAP=2'b10, DONE=2'b11.
  - Localparam IDX_W = $clog2(PAT_W).
- Sub-module pattern_shifter:
  - Holds pattern_cap and the bit-index down-counter.
  - Inputs load, advance.
  - Outputs bit, last_bit, first_bit.
- FSM, repeat counter and gap counter live in the top level.

Test Plan:
1. Single frame: pattern=8'h0B, len_m1=3, repeat_m1=0, gap=0, start pulse -> bit_out 1,0,1,1 in cycles 1-4 with bit_valid=1 and first_bit only in cycle 1; done=1 in cycle 5; busy high in cycles 1-5, low in cycle 6.
2. Back-to-back repeats: pattern=8'h0D, len_m1=3, repeat_m1=2, gap=0 -> 12 contiguous valid bits 110111011101; first_bit in cycles 1, 5, 9; done in cycle 13.
3. Gapped repeats: pattern=8'h02, len_m1=1, repeat_m1=1, gap=2 -> bit_valid/bit_out: 1/1, 1/0, 0/0, 0/0, 1/1, 1/0; done in cycle 7.
4. Abort: pattern=8'hA5, len_m1=7, abort asserted during the 2nd bit -> bit_valid=0 and busy=0 from the next cycle, no done pulse. A new start in IDLE then produces 10100101 correctly.
5. Isolation: start re-pulsed and pattern changed to 8'hFF mid-frame of test 1 -> output is still 1,0,1,1 and exactly one done pulse.
6. Async reset mid-GAP of test 3 -> all outputs 0 before the next clk edge. After reset deasserts, start with len_m1=0, pattern=8'h01 -> a single 1 bit, done the following cycle.
